// File: rtl/getir_istek_zamanlayici.sv
// getir_istek_zamanlayici: issues PS fetches to L1B, tags in-order responses with their PS and drains stale ones after a flush
module getir_istek_zamanlayici #(
  parameter int PS_BIT       = 32,
  parameter int VERI_BIT     = 32,
  parameter int MAX_BEKLEYEN = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [PS_BIT-1:0]                     g1_ps_i,
  input  logic                                  g1_ps_gecerli_i,
  output logic                                  g1_ps_hazir_o,
  output logic [PS_BIT-1:0]                     l1b_istek_ps_o,
  output logic                                  l1b_istek_gecerli_o,
  input  logic                                  l1b_istek_hazir_i,
  input  logic [VERI_BIT-1:0]                   l1b_buyruk_i,
  input  logic                                  l1b_buyruk_gecerli_i,
  output logic                                  l1b_buyruk_hazir_o,
  output logic [VERI_BIT-1:0]                   g2_buyruk_o,
  output logic [PS_BIT-1:0]                     g2_ps_o,
  output logic                                  g2_gecerli_o,
  input  logic                                  g2_hazir_i,
  input  logic                                  cek_bosalt_i,
  output logic [$clog2(MAX_BEKLEYEN+1)-1:0]     bekleyen_sayisi_o,
  output logic                                  hata_o
);
  localparam int CW = $clog2(MAX_BEKLEYEN + 1);
  localparam int PW = $clog2(MAX_BEKLEYEN);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BEKLEYEN);
  typedef enum logic {CALIS, BOSALT} durum_t;
  durum_t durum_q, durum_d;
  logic [PS_BIT-1:0] fifo_q [MAX_BEKLEYEN];
  logic [PW-1:0] yaz_q, yaz_d, oku_q, oku_d;
  logic [CW-1:0] canli_q, canli_d, bayat_q, bayat_d, toplam;
  logic hata_q, hata_d, itme, cekme, yanit;
  always_comb begin
    toplam = canli_q + bayat_q;
    l1b_istek_gecerli_o = g1_ps_gecerli_i && (toplam < MAXC) && !cek_bosalt_i;
    g1_ps_hazir_o = l1b_istek_gecerli_o && l1b_istek_hazir_i;
    itme = g1_ps_hazir_o;
    g2_gecerli_o = !cek_bosalt_i && durum_q == CALIS && canli_q != '0 && l1b_buyruk_gecerli_i;
    l1b_buyruk_hazir_o = cek_bosalt_i ? toplam != '0 : durum_q == BOSALT ? 1'b1 : canli_q != '0 && g2_hazir_i;
    yanit = l1b_buyruk_gecerli_i && l1b_buyruk_hazir_o;
    cekme = yanit && !cek_bosalt_i && durum_q == CALIS;
    hata_d = hata_q || (l1b_buyruk_gecerli_i && toplam == '0);
    // a flush turns every live request into a stale one; a response taken that cycle is already gone
    bayat_d = cek_bosalt_i ? bayat_q + canli_q - CW'(yanit) : bayat_q - CW'(yanit && durum_q == BOSALT);
    canli_d = cek_bosalt_i ? '0 : canli_q + CW'(itme) - CW'(cekme);
    yaz_d = cek_bosalt_i ? '0 : yaz_q + PW'(itme);
    oku_d = cek_bosalt_i ? '0 : oku_q + PW'(cekme);
    durum_d = bayat_d != '0 ? BOSALT : CALIS;
    l1b_istek_ps_o = g1_ps_i;
    g2_buyruk_o = l1b_buyruk_i;
    g2_ps_o = fifo_q[oku_q];
    bekleyen_sayisi_o = toplam;
    hata_o = hata_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q <= CALIS;
      yaz_q   <= '0;
      oku_q   <= '0;
      canli_q <= '0;
      bayat_q <= '0;
      hata_q  <= 1'b0;
    end else begin
      durum_q <= durum_d;
      yaz_q   <= yaz_d;
      oku_q   <= oku_d;
      canli_q <= canli_d;
      bayat_q <= bayat_d;
      hata_q  <= hata_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (itme) fifo_q[yaz_q] <= g1_ps_i;
  end
endmodule

// File: tb/tb_getir_istek_zamanlayici.sv
// tb_getir_istek_zamanlayici: directed scenarios plus a randomized run against a queue-based reference model
module tb_getir_istek_zamanlayici;
  localparam int MAXB = 4;
  logic clk_i = 1'b0;
  logic rst_i;
  logic [31:0] g1_ps_i, l1b_istek_ps_o, l1b_buyruk_i, g2_buyruk_o, g2_ps_o;
  logic g1_ps_gecerli_i, g1_ps_hazir_o, l1b_istek_gecerli_o, l1b_istek_hazir_i;
  logic l1b_buyruk_gecerli_i, l1b_buyruk_hazir_o, g2_gecerli_o, g2_hazir_i, cek_bosalt_i, hata_o;
  logic [2:0] bekleyen_sayisi_o;
  int n_cmp = 0;
  int n_err = 0;

  getir_istek_zamanlayici #(.PS_BIT(32), .VERI_BIT(32), .MAX_BEKLEYEN(MAXB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .g1_ps_i(g1_ps_i), .g1_ps_gecerli_i(g1_ps_gecerli_i), .g1_ps_hazir_o(g1_ps_hazir_o),
    .l1b_istek_ps_o(l1b_istek_ps_o), .l1b_istek_gecerli_o(l1b_istek_gecerli_o), .l1b_istek_hazir_i(l1b_istek_hazir_i),
    .l1b_buyruk_i(l1b_buyruk_i), .l1b_buyruk_gecerli_i(l1b_buyruk_gecerli_i), .l1b_buyruk_hazir_o(l1b_buyruk_hazir_o),
    .g2_buyruk_o(g2_buyruk_o), .g2_ps_o(g2_ps_o), .g2_gecerli_o(g2_gecerli_o), .g2_hazir_i(g2_hazir_i),
    .cek_bosalt_i(cek_bosalt_i), .bekleyen_sayisi_o(bekleyen_sayisi_o), .hata_o(hata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic g1v, input logic [31:0] ps, input logic ih, input logic bv,
                       input logic [31:0] d, input logic g2h, input logic fl);
    g1_ps_gecerli_i = g1v; g1_ps_i = ps; l1b_istek_hazir_i = ih;
    l1b_buyruk_gecerli_i = bv; l1b_buyruk_i = d; g2_hazir_i = g2h; cek_bosalt_i = fl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic issue(input logic [31:0] ps);
    drive(1, ps, 1, 0, 0, 0, 0);
    n_cmp++; if (g1_ps_hazir_o !== 1'b1) begin n_err++; $display("FAIL issue_hazir ps=%h got %b exp 1", ps, g1_ps_hazir_o); end
    n_cmp++; if (l1b_istek_ps_o !== ps) begin n_err++; $display("FAIL issue_ps got %h exp %h", l1b_istek_ps_o, ps); end
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bekleyen_sayisi_o !== 3'd0) begin n_err++; $display("FAIL reset_bekleyen got %0d exp 0", bekleyen_sayisi_o); end
    n_cmp++; if (hata_o !== 1'b0) begin n_err++; $display("FAIL reset_hata got %b exp 0", hata_o); end
    n_cmp++; if ({g1_ps_hazir_o, l1b_istek_gecerli_o, l1b_buyruk_hazir_o, g2_gecerli_o} !== 4'b0) begin
      n_err++; $display("FAIL reset_handshake got %b exp 0000", {g1_ps_hazir_o, l1b_istek_gecerli_o, l1b_buyruk_hazir_o, g2_gecerli_o}); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) issue(32'h100 + 4 * i);
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bekleyen_sayisi_o !== 3'd3) begin n_err++; $display("FAIL basic_bekleyen got %0d exp 3", bekleyen_sayisi_o); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 32'hD000 + i, 1, 0);
      n_cmp++; if (g2_gecerli_o !== 1'b1) begin n_err++; $display("FAIL basic_g2v[%0d] got %b exp 1", i, g2_gecerli_o); end
      n_cmp++; if (g2_ps_o !== 32'h100 + 4 * i) begin n_err++; $display("FAIL basic_g2ps[%0d] got %h exp %h", i, g2_ps_o, 32'h100 + 4 * i); end
      n_cmp++; if (g2_buyruk_o !== 32'hD000 + i) begin n_err++; $display("FAIL basic_data[%0d] got %h exp %h", i, g2_buyruk_o, 32'hD000 + i); end
      n_cmp++; if (l1b_buyruk_hazir_o !== 1'b1) begin n_err++; $display("FAIL basic_bhazir[%0d] got %b exp 1", i, l1b_buyruk_hazir_o); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bekleyen_sayisi_o !== 3'd0) begin n_err++; $display("FAIL basic_empty got %0d exp 0", bekleyen_sayisi_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) issue(32'h300 + 4 * i);
    drive(1, 32'h310, 1, 0, 0, 1, 0);
    n_cmp++; if (bekleyen_sayisi_o !== 3'd4) begin n_err++; $display("FAIL full_bekleyen got %0d exp 4", bekleyen_sayisi_o); end
    n_cmp++; if (g1_ps_hazir_o !== 1'b0) begin n_err++; $display("FAIL full_hazir got %b exp 0", g1_ps_hazir_o); end
    drive(1, 32'h310, 1, 1, 32'hE0, 1, 0);
    n_cmp++; if (g1_ps_hazir_o !== 1'b0) begin n_err++; $display("FAIL full_same_cycle got %b exp 0", g1_ps_hazir_o); end
    n_cmp++; if (g2_ps_o !== 32'h300) begin n_err++; $display("FAIL full_ps0 got %h exp 300", g2_ps_o); end
    tick();
    drive(1, 32'h310, 1, 0, 0, 1, 0);
    n_cmp++; if (g1_ps_hazir_o !== 1'b1) begin n_err++; $display("FAIL full_resume got %b exp 1", g1_ps_hazir_o); end
    tick();
    for (int i = 1; i < 5; i++) begin
      drive(0, 0, 0, 1, 32'hE0 + i, 1, 0);
      n_cmp++; if (g2_gecerli_o !== 1'b1 || g2_ps_o !== 32'h300 + 4 * i) begin
        n_err++; $display("FAIL full_drain[%0d] got v=%b ps=%h exp v=1 ps=%h", i, g2_gecerli_o, g2_ps_o, 32'h300 + 4 * i); end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) issue(32'h400 + 4 * i);
    drive(1, 32'h999, 1, 0, 0, 1, 1);
    n_cmp++; if (l1b_istek_gecerli_o !== 1'b0) begin n_err++; $display("FAIL flush_istek got %b exp 0", l1b_istek_gecerli_o); end
    n_cmp++; if (l1b_buyruk_hazir_o !== 1'b1) begin n_err++; $display("FAIL flush_bhazir got %b exp 1", l1b_buyruk_hazir_o); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bekleyen_sayisi_o !== 3'd3) begin n_err++; $display("FAIL flush_bayat got %0d exp 3", bekleyen_sayisi_o); end
    issue(32'h200);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 32'hBAD0 + i, 0, 0);
      n_cmp++; if (g2_gecerli_o !== 1'b0 || l1b_buyruk_hazir_o !== 1'b1) begin
        n_err++; $display("FAIL flush_stale[%0d] got g2v=%b bh=%b exp g2v=0 bh=1", i, g2_gecerli_o, l1b_buyruk_hazir_o); end
      tick();
    end
    drive(0, 0, 0, 1, 32'h600D, 1, 0);
    n_cmp++; if (g2_gecerli_o !== 1'b1 || g2_ps_o !== 32'h200) begin
      n_err++; $display("FAIL flush_live got v=%b ps=%h exp v=1 ps=200", g2_gecerli_o, g2_ps_o); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bekleyen_sayisi_o !== 3'd0) begin n_err++; $display("FAIL flush_end got %0d exp 0", bekleyen_sayisi_o); end
  endtask

  task automatic test_flush_resp();
    issue(32'h500); issue(32'h504);
    drive(1, 32'h508, 1, 1, 32'h77, 1, 1);
    n_cmp++; if (l1b_istek_gecerli_o !== 1'b0 || g2_gecerli_o !== 1'b0 || l1b_buyruk_hazir_o !== 1'b1) begin
      n_err++; $display("FAIL flushresp got iv=%b g2v=%b bh=%b exp 0 0 1", l1b_istek_gecerli_o, g2_gecerli_o, l1b_buyruk_hazir_o); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bekleyen_sayisi_o !== 3'd1) begin n_err++; $display("FAIL flushresp_bayat got %0d exp 1", bekleyen_sayisi_o); end
    drive(0, 0, 0, 1, 32'h78, 1, 0);
    n_cmp++; if (g2_gecerli_o !== 1'b0) begin n_err++; $display("FAIL flushresp_stale got %b exp 0", g2_gecerli_o); end
    tick();
  endtask

  task automatic test_backpressure();
    issue(32'h600);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 32'hCAFE, 0, 0);
      n_cmp++; if (l1b_buyruk_hazir_o !== 1'b0 || g2_gecerli_o !== 1'b1 || g2_ps_o !== 32'h600 || g2_buyruk_o !== 32'hCAFE) begin
        n_err++; $display("FAIL bp_hold[%0d] got bh=%b v=%b ps=%h d=%h exp 0 1 600 cafe", i, l1b_buyruk_hazir_o, g2_gecerli_o, g2_ps_o, g2_buyruk_o); end
      tick();
    end
    drive(0, 0, 0, 1, 32'hCAFE, 1, 0);
    n_cmp++; if (l1b_buyruk_hazir_o !== 1'b1) begin n_err++; $display("FAIL bp_accept got %b exp 1", l1b_buyruk_hazir_o); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bekleyen_sayisi_o !== 3'd0) begin n_err++; $display("FAIL bp_empty got %0d exp 0", bekleyen_sayisi_o); end
  endtask

  task automatic test_error_reset();
    drive(0, 0, 0, 1, 32'h1, 1, 0);
    n_cmp++; if (l1b_buyruk_hazir_o !== 1'b0) begin n_err++; $display("FAIL err_bhazir got %b exp 0", l1b_buyruk_hazir_o); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (hata_o !== 1'b1) begin n_err++; $display("FAIL err_set got %b exp 1", hata_o); end
    tick(); tick();
    n_cmp++; if (hata_o !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b exp 1", hata_o); end
    issue(32'h700); issue(32'h704);
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bekleyen_sayisi_o !== 3'd2) begin n_err++; $display("FAIL err_bekleyen got %0d exp 2", bekleyen_sayisi_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bekleyen_sayisi_o !== 3'd0 || hata_o !== 1'b0) begin
      n_err++; $display("FAIL err_reset got bek=%0d hata=%b exp 0 0", bekleyen_sayisi_o, hata_o); end
  endtask

  task automatic test_random();
    logic [31:0] live[$];
    int stale = 0;
    bit err = 0;
    logic g1v, ih, bv, g2h, fl, e_iv, e_gh, e_bh, e_g2v, resp;
    logic [31:0] ps, d;
    int total;
    rst_i = 1'b1; drive(0, 0, 0, 0, 0, 0, 0); tick(); rst_i = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      total = live.size() + stale;
      g1v = ($urandom % 4) != 0; ps = $urandom; ih = ($urandom % 3) != 0;
      bv = total > 0 ? $urandom_range(0, 1) == 1 : ($urandom % 60) == 0;
      d = $urandom; g2h = ($urandom % 4) != 0; fl = ($urandom % 20) == 0;
      drive(g1v, ps, ih, bv, d, g2h, fl);
      e_iv = g1v && total < MAXB && !fl;
      e_gh = e_iv && ih;
      e_g2v = !fl && stale == 0 && live.size() > 0 && bv;
      e_bh = fl ? total > 0 : stale > 0 ? 1'b1 : live.size() > 0 ? g2h : 1'b0;
      n_cmp++; if ({l1b_istek_gecerli_o, g1_ps_hazir_o, l1b_buyruk_hazir_o, g2_gecerli_o} !== {e_iv, e_gh, e_bh, e_g2v}) begin
        n_err++; $display("FAIL rnd_hs c=%0d got %b exp %b", c, {l1b_istek_gecerli_o, g1_ps_hazir_o, l1b_buyruk_hazir_o, g2_gecerli_o}, {e_iv, e_gh, e_bh, e_g2v}); end
      n_cmp++; if (bekleyen_sayisi_o !== 3'(total) || hata_o !== err) begin
        n_err++; $display("FAIL rnd_cnt c=%0d got bek=%0d hata=%b exp %0d %b", c, bekleyen_sayisi_o, hata_o, total, err); end
      if (e_g2v) begin
        n_cmp++; if (g2_ps_o !== live[0] || g2_buyruk_o !== d) begin
          n_err++; $display("FAIL rnd_g2 c=%0d got ps=%h d=%h exp ps=%h d=%h", c, g2_ps_o, g2_buyruk_o, live[0], d); end
      end
      resp = bv && e_bh;
      if (bv && total == 0) err = 1;
      if (fl) begin
        stale = stale + live.size() - int'(resp);
        live.delete();
      end else begin
        if (resp && stale > 0) stale--;
        else if (resp) void'(live.pop_front());
        if (e_gh) live.push_back(ps);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_flush();
    test_flush_resp();
    test_backpressure();
    test_error_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
